// File: rtl/regfile_pkg.sv
// Shared sizing constants for the datapath register file.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // One write-port request as seen by the register array.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational read port: 32:1 mux over R1..R31 with R0 forced to zero.
module reg_file_rd_port
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:1][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               addr,
  output logic [DATA_W-1:0]               data
);
  // Slot 0 is a constant zero so the mux needs no special case past the guard.
  logic [NUM_REGS-1:0][DATA_W-1:0] full;
  assign full = {regs, {DATA_W{1'b0}}};

  // Zero-latency select; address 0 never reaches storage.
  always_comb begin
    data = '0;
    if (addr != ZERO_REG) data = full[addr];
  end
endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
module reg_file
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] rd_addrA,
  input  logic [ADDR_W-1:0] rd_addrB,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_dataA,
  output logic [DATA_W-1:0] rd_dataB
);
  wr_req_t wr;
  assign wr = '{en: wr_en, addr: wr_addr, data: wr_data};

  // R0 has no storage; only R1..R31 exist as flops.
  logic [NUM_REGS-1:1][DATA_W-1:0] regs;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    // Reset wins over a same-cycle write; otherwise load on address match.
    always_ff @(posedge clk) begin
      if (nrst)
        regs[i] <= '0;
      else if (wr.en && wr.addr == ADDR_W'(i))
        regs[i] <= wr.data;
    end
  end

  reg_file_rd_port u_rd_a (.regs(regs), .addr(rd_addrA), .data(rd_dataA));
  reg_file_rd_port u_rd_b (.regs(regs), .addr(rd_addrB), .data(rd_dataB));
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps then randomized traffic
// against an array model of the architectural registers.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  rd_addrA, rd_addrB, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_dataA, rd_dataB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .nrst(nrst),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_dataA(rd_dataA), .rd_dataB(rd_dataB)
  );

  // Architectural read: register 0 is always zero.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model commits what the inputs requested.
  task automatic step();
    @(posedge clk);
    if (nrst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wr_en && wr_addr != 5'd0) begin
      model[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [4:0] b);
    rd_addrA = a;
    rd_addrB = b;
    #1;
    chk({tag, "_A"}, rd_dataA, exp_rd(a));
    chk({tag, "_B"}, rd_dataB, exp_rd(b));
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    nrst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addrA = '0; rd_addrB = '0;

    // Reset held for 10 cycles, then every address reads zero.
    repeat (10) step();
    nrst = 1'b0;
    for (int i = 0; i < 32; i++) rd_chk("reset_sweep", 5'(i), 5'(31 - i));

    // Writes to R0 are dropped.
    write(5'd0, 32'hFFFF_FFFF);
    rd_chk("r0_hardwire", 5'd0, 5'd0);
    chk("r0_const_A", rd_dataA, 32'h0);
    chk("r0_const_B", rd_dataB, 32'h0);

    // Fill R1..R31 with distinct patterns, idle cycle between writes.
    for (int i = 1; i < 32; i++) begin
      write(5'(i), 32'hA5A5_0000 | 32'(i));
      step();
    end
    rd_addrB = 5'd0;
    for (int i = 0; i < 32; i++) begin
      rd_addrA = 5'(i); #1;
      chk("fill_A", rd_dataA, (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i)));
    end
    for (int i = 0; i < 32; i++) begin
      rd_addrB = 5'(i); #1;
      chk("fill_B", rd_dataB, (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i)));
    end

    // Write enable low must hold the register.
    write(5'd5, 32'h1234_5678);
    wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_en = 1'b0;
    repeat (3) step();
    rd_addrA = 5'd5; rd_addrB = 5'd5; #1;
    chk("we_gate_A", rd_dataA, 32'h1234_5678);
    chk("we_gate_B", rd_dataB, 32'h1234_5678);

    // Same-cycle read/write, both ports on R7: old value until the edge.
    rd_addrA = 5'd7; rd_addrB = 5'd7;
    wr_addr = 5'd7; wr_data = 32'hCAFE_F00D; wr_en = 1'b1; #1;
    chk("rw_old_A", rd_dataA, 32'hA5A5_0007);
    chk("rw_old_B", rd_dataB, 32'hA5A5_0007);
    step();
    wr_en = 1'b0;
    chk("rw_new_A", rd_dataA, 32'hCAFE_F00D);
    chk("rw_new_B", rd_dataB, 32'hCAFE_F00D);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      nrst    = ($urandom_range(0, 39) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_chk("rand_pre", 5'($urandom_range(0, 31)), wr_addr);
      step();
      rd_chk("rand_post", 5'($urandom_range(0, 31)), wr_addr);
    end
    nrst = 1'b0; wr_en = 1'b0;

    // Fill a few registers, then reset and write in the same cycle.
    write(5'd3, 32'h3333_3333);
    write(5'd9, 32'h9999_9999);
    nrst = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    step();
    nrst = 1'b0; wr_en = 1'b0;
    rd_addrA = 5'd9; rd_addrB = 5'd3; #1;
    chk("rst_prio_r9", rd_dataA, 32'h0);
    chk("rst_prio_r3", rd_dataB, 32'h0);
    for (int i = 0; i < 32; i++) rd_chk("rst_prio_sweep", 5'(i), 5'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the processor datapath, sitting between the decode and execute stages.
- Two independent combinational read ports (A, B) and one synchronous write port.
- Register 0 is hardwired to zero, RISC-style.
- All storage is cleared by a synchronous reset.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- nrst  input  1  synchronous reset, active-high. Despite the codebase name, nrst=1 resets on the next rising clk edge; nrst=0 is normal operation.
- rd_addrA  input  ADDR_W  read port A address.
- rd_addrB  input  ADDR_W  read port B address.
- wr_addr  input  ADDR_W  write address.
- wr_en  input  1  write enable, active-high.
- wr_data  input  DATA_W  write data.
- rd_dataA  output  DATA_W  contents of register rd_addrA.
- rd_dataB  output  DATA_W  contents of register rd_addrB.

Behaviour:
- Storage: registers R1..R31 are DATA_W flops each. R0 is not stored and always reads 0.
- Reset: on a rising clk edge with nrst=1, R1..R31 become 0. Reset has priority over any write in the same cycle. Reset mid-operation discards pending writes. After reset, both read ports return 0 for every address.
- Write: on a rising clk edge with nrst=0, wr_en=1 and wr_addr!=0, R[wr_addr] <= wr_data.
  - wr_en=0: no register changes.
  - Writes to address 0 are silently ignored; R0 stays 0.
- Read: combinational with zero-cycle latency.
  - rd_dataX = 0 if rd_addrX==0, else R[rd_addrX].
  - Output follows an address change within the same cycle.
- Read/write same address, same cycle: the read port shows the old value until the clock edge, then the new value. There is no write-to-read bypass.
- Ports A and B are fully independent. Both may address the same register simultaneously and return identical data.
- No X propagation after reset: every output is defined for every address.
- No other state, handshake or FSM.

Decomposition:
- Shared package (regfile_pkg): DATA_W, ADDR_W, NUM_REGS (=32), ZERO_REG (=5'd0).
- Optional single sub-module: reg_file_rd_port, a 32:1 mux with R0-forced-zero. It is instantiated twice (A, B).
- Write decode and the register array stay in the top.

Test Plan:
- Reset: hold nrst=1 for 10 cycles, release, then sweep rd_addrA and rd_addrB over 0..31 -> all reads 0.
- R0 hardwire: write wr_addr=0, wr_data=32'hFFFFFFFF, wr_en=1 for one cycle -> rd_dataA and rd_dataB at address 0 read 32'h00000000.
- Fill and readback: for addresses 1..31, write a distinct pattern (e.g. 32'hA5A5_0000 | addr) with wr_en pulsed one cycle then deasserted one cycle. Sweep port A over 0..31, then port B over 0..31 -> address 0 reads 0 and every other address reads its pattern. Expect 64/64 matches.
- Write-enable gating: with R5=32'h12345678, present wr_addr=5, wr_data=32'hDEADBEEF, wr_en=0 for 3 cycles -> R5 still reads 32'h12345678.
- Same-cycle read/write and dual port: set rd_addrA=rd_addrB=7 and write 32'hCAFEF00D to address 7 -> both ports show the old value before the edge and 32'hCAFEF00D after it.
- Reset priority: assert nrst=1 and wr_en=1 (addr 9, data 32'h1) in the same cycle -> R9 reads 0; all previously written registers read 0.
